tv_clip: RTL and testbench

- Downstream stage of the horizontal-difference block in the GAP-TV datapath.
- Once per start pulse, sweeps the difference-result BRAM and clips every fp16 lane to [-lambda, +lambda]. This is the Chambolle dual-variable projection.
- Writes the clipped words to a second BRAM, using the same 16-lane x 16-bit word format.
- Pure magnitude compare on fp16 bit patterns, so no floating-point IP is needed.

---
 rtl/tv_pkg.sv | 25 ++
 rtl/tv_clip_lane.sv | 21 ++
 rtl/tv_clip.sv | 131 +++++++++++++
 tb/tb_tv_clip.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tv_pkg.sv
// Shared constants, fp16 field values and FSM state type for the GAP-TV clip stage.
package tv_pkg;

  localparam int PORT_SIZE = 16;
  localparam int COL_WIDTH = 4;
  localparam int ROW_NUM   = 48;
  localparam int WORDS     = ROW_NUM * COL_WIDTH;
  localparam int RD_LAT    = 1;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = PORT_SIZE * 16;
  localparam int CNT_W     = $clog2(PORT_SIZE + 1);

  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [CNT_W-1:0] count_ones(input logic [PORT_SIZE-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PORT_SIZE; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/tv_clip_lane.sv
// One fp16 lane of the dual-variable projection: clip magnitude to lam, zero NaNs.
module tv_clip_lane
  import tv_pkg::*;
(
  input  logic [15:0] x,
  input  logic [14:0] lam,
  output logic [15:0] y,
  output logic        is_nan,
  output logic        is_clipped
);

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    is_nan     = (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'd0);
    is_clipped = !is_nan && (x[14:0] > lam);
    y          = x;
    if (is_nan)          y = 16'h0000;
    else if (is_clipped) y = {x[15], lam};
  end

endmodule

// File: rtl/tv_clip.sv
// Sweeps the difference BRAM once per start and writes every lane clipped to [-lambda, +lambda].
// Optional clipped-lane counter port clip_cnt is built when TV_CLIP_STATS_EN is defined.
module tv_clip
  import tv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       lambda,
  output logic              busy,
  output logic              done,
  output logic              nan_seen,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] din,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] dout
`ifdef TV_CLIP_STATS_EN
  ,
  output logic [15:0]       clip_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_t state_q, state_d;

  logic [14:0]       lam_q;
  logic              rd_vld  [RD_LAT];
  logic [ADDR_W-1:0] rd_addr [RD_LAT];

  logic [DATA_W-1:0]    clip_word;
  logic [PORT_SIZE-1:0] nan_vec;
  logic [PORT_SIZE-1:0] clip_vec;

  logic accept;
  logic last_rd;
  logic last_wr;
  logic lambda_nan;
  logic unused_bits;

  assign accept     = (state_q == IDLE) && start;
  assign last_rd    = ren && (raddr == LAST_ADDR);
  assign last_wr    = wen && (waddr == LAST_ADDR);
  assign lambda_nan = (lambda[14:10] == FP16_EXP_MAX) && (lambda[9:0] != 10'd0);

  for (genvar g = 0; g < PORT_SIZE; g++) begin : g_lane
    tv_clip_lane u_lane (
      .x          (din[g*16 +: 16]),
      .lam        (lam_q),
      .y          (clip_word[g*16 +: 16]),
      .is_nan     (nan_vec[g]),
      .is_clipped (clip_vec[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = RUN;
      RUN:     if (last_rd) state_d = DRAIN;
      DRAIN:   if (last_wr) state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    ren  = (state_q == RUN);
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the valid pipeline is reset so no write can issue after rst is sampled.
      raddr    <= '0;
      lam_q    <= '0;
      wen      <= 1'b0;
      waddr    <= '0;
      dout     <= '0;
      nan_seen <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld[i]  <= 1'b0;
        rd_addr[i] <= '0;
      end
    end else begin
      if (accept) begin
        lam_q    <= lambda_nan ? FP16_INF_MAG : lambda[14:0];
        nan_seen <= 1'b0;
      end
      if (ren) raddr <= last_rd ? '0 : raddr + ADDR_W'(1);

      rd_vld[0]  <= ren;
      rd_addr[0] <= raddr;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_addr[i] <= rd_addr[i-1];
      end

      wen <= rd_vld[RD_LAT-1];
      if (rd_vld[RD_LAT-1]) begin
        waddr <= rd_addr[RD_LAT-1];
        dout  <= clip_word;
        if (|nan_vec) nan_seen <= 1'b1;
      end
    end
  end

`ifdef TV_CLIP_STATS_EN
  logic [16:0] cnt_sum;
  assign cnt_sum     = {1'b0, clip_cnt} + 17'(count_ones(clip_vec));
  assign unused_bits = lambda[15];

  always_ff @(posedge clk) begin
    if (rst)                    clip_cnt <= '0;
    else if (accept)            clip_cnt <= '0;
    else if (rd_vld[RD_LAT-1])  clip_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`else
  assign unused_bits = ^{lambda[15], clip_vec};
`endif

endmodule

// File: tb/tb_tv_clip.sv
// Randomised scoreboard bench for tv_clip; define TV_CLIP_STATS_EN to also check clip_cnt.
module tb_tv_clip;
  import tv_pkg::*;

  localparam int DONE_CYC = WORDS + 2 + RD_LAT;
  localparam int FIRST_WR = 2 + RD_LAT;
  localparam int LAST_WR  = WORDS + 1 + RD_LAT;

  logic              clk;
  logic              rst;
  logic              start;
  logic [15:0]       lambda;
  logic              busy;
  logic              done;
  logic              nan_seen;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] din;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] dout;
`ifdef TV_CLIP_STATS_EN
  logic [15:0]       clip_cnt;
`endif

  tv_clip dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .lambda   (lambda),
    .busy     (busy),
    .done     (done),
    .nan_seen (nan_seen),
    .ren      (ren),
    .raddr    (raddr),
    .din      (din),
    .wen      (wen),
    .waddr    (waddr),
    .dout     (dout)
`ifdef TV_CLIP_STATS_EN
    ,
    .clip_cnt (clip_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source BRAM model with one cycle of read latency.
  logic [DATA_W-1:0] src_mem [WORDS];
  always @(posedge clk) if (ren) din <= src_mem[raddr];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_clips;
  bit  exp_nan;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_write: got write to %0d, expected none", waddr);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", DATA_W'(waddr), DATA_W'(mon_e.addr));
        check("dout", dout, mon_e.data);
      end
    end
  end

  // Reference model: fp16 magnitude arithmetic straight from the clip rules.
  function automatic int unsigned mag(input logic [15:0] v);
    return int'(v & 16'h7FFF);
  endfunction

  function automatic bit is_nan16(input logic [15:0] v);
    return mag(v) > 32'h7C00;
  endfunction

  function automatic int unsigned limit_of(input logic [15:0] lamb);
    return is_nan16(lamb) ? 32'h7C00 : mag(lamb);
  endfunction

  function automatic logic [15:0] clip_ref(input logic [15:0] x, input logic [15:0] lamb);
    if (is_nan16(x)) return 16'h0000;
    if (mag(x) > limit_of(lamb)) return {x[15], 15'(limit_of(lamb))};
    return x;
  endfunction

  task automatic build_expected(input logic [15:0] lamb);
    wr_t e;
    logic [15:0] x;
    exp_nan   = 1'b0;
    exp_clips = 0;
    for (int k = 0; k < WORDS; k++) begin
      e.addr = ADDR_W'(k);
      for (int l = 0; l < PORT_SIZE; l++) begin
        x = src_mem[k][l*16 +: 16];
        e.data[l*16 +: 16] = clip_ref(x, lamb);
        if (is_nan16(x)) exp_nan = 1'b1;
        else if (mag(x) > limit_of(lamb)) exp_clips++;
      end
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [15:0] rand_lane(input bit no_nan);
    logic [15:0] x;
    x = 16'($urandom);
    if (no_nan && is_nan16(x)) x[9:0] = 10'd0;
    return x;
  endfunction

  task automatic fill_random(input bit no_nan);
    for (int k = 0; k < WORDS; k++)
      for (int l = 0; l < PORT_SIZE; l++) src_mem[k][l*16 +: 16] = rand_lane(no_nan);
  endtask

  task automatic pulse_start(input logic [15:0] lamb);
    @(negedge clk);
    lambda = lamb;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    lambda = 16'($urandom);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] lamb, input bit poke);
    int done_at = -1;
    int wcnt = 0;
    int first = -1;
    int last = -1;
    build_expected(lamb);
    pulse_start(lamb);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_busy_c1"}, DATA_W'(busy), 1);
        check({tag, "_ren_c1"}, DATA_W'(ren), 1);
        check({tag, "_raddr_c1"}, DATA_W'(raddr), 0);
        check({tag, "_nan_clr"}, DATA_W'(nan_seen), 0);
      end
      if (poke) begin
        if (i == 50) start = 1'b1;
        if (i == 51) start = 1'b0;
      end
      if (wen) begin
        wcnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (done) begin
        done_at = i;
        break;
      end
    end
    check({tag, "_done_cycle"}, DATA_W'(done_at), DATA_W'(DONE_CYC));
    check({tag, "_wen_count"}, DATA_W'(wcnt), DATA_W'(WORDS));
    check({tag, "_first_wr"}, DATA_W'(first), DATA_W'(FIRST_WR));
    check({tag, "_last_wr"}, DATA_W'(last), DATA_W'(LAST_WR));
    check({tag, "_busy_at_done"}, DATA_W'(busy), 0);
    check({tag, "_queue_empty"}, DATA_W'(exp_q.size()), 0);
    check({tag, "_nan_seen"}, DATA_W'(nan_seen), DATA_W'(exp_nan));
`ifdef TV_CLIP_STATS_EN
    check({tag, "_clip_cnt"}, DATA_W'(clip_cnt), DATA_W'(exp_clips > 65535 ? 65535 : exp_clips));
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, DATA_W'(done), 0);
    check({tag, "_idle_after"}, DATA_W'(busy), 0);
    check({tag, "_nan_hold"}, DATA_W'(nan_seen), DATA_W'(exp_nan));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, DATA_W'(busy), 0);
    check({tag, "_done"}, DATA_W'(done), 0);
    check({tag, "_ren"}, DATA_W'(ren), 0);
    check({tag, "_wen"}, DATA_W'(wen), 0);
    check({tag, "_nan"}, DATA_W'(nan_seen), 0);
    check({tag, "_raddr"}, DATA_W'(raddr), 0);
    check({tag, "_waddr"}, DATA_W'(waddr), 0);
    check({tag, "_dout"}, dout, 0);
`ifdef TV_CLIP_STATS_EN
    check({tag, "_clip_cnt"}, DATA_W'(clip_cnt), 0);
`endif
  endtask

  task automatic run_abort(input logic [15:0] lamb, input int at);
    int dones = 0;
    build_expected(lamb);
    pulse_start(lamb);
    for (int i = 1; i <= at; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_outputs("abort");
    repeat (300) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", DATA_W'(dones), 0);
    check("abort_idle", DATA_W'(busy), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    lambda = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed magnitudes against lambda = 1.0.
    fill_random(1'b1);
    src_mem[0][0*16 +: 16] = 16'h4000;
    src_mem[0][1*16 +: 16] = 16'hC200;
    src_mem[0][2*16 +: 16] = 16'h3800;
    run_frame("basic", 16'h3C00, 1'b0);

    // Infinities and negative zero.
    for (int k = 0; k < WORDS; k++)
      for (int l = 0; l < PORT_SIZE; l++)
        case ((k + l) % 4)
          0:       src_mem[k][l*16 +: 16] = 16'h7C00;
          1:       src_mem[k][l*16 +: 16] = 16'hFC00;
          2:       src_mem[k][l*16 +: 16] = 16'h8000;
          default: src_mem[k][l*16 +: 16] = rand_lane(1'b1);
        endcase
    run_frame("inf", 16'h3C00, 1'b0);

    // Single NaN lane sets the sticky flag.
    fill_random(1'b1);
    src_mem[5][7*16 +: 16] = 16'h7E00;
    run_frame("nan", 16'h3C00, 1'b0);

    // Address sweep, start pulsed mid-sweep must be ignored.
    for (int k = 0; k < WORDS; k++)
      for (int l = 0; l < PORT_SIZE; l++) src_mem[k][l*16 +: 16] = 16'(k);
    run_frame("sweep", 16'h7BFF, 1'b1);

    // Reset mid-sweep, then a full clean sweep.
    fill_random(1'b0);
    run_abort(16'h3C00, 100);
    run_frame("post_abort", 16'h3C00, 1'b0);

    // Every lane clipped.
    for (int k = 0; k < WORDS; k++)
      for (int l = 0; l < PORT_SIZE; l++) src_mem[k][l*16 +: 16] = 16'h4000;
    run_frame("all_clip", 16'h3C00, 1'b0);

    // NaN lambda behaves as infinity.
    fill_random(1'b0);
    run_frame("nan_lambda", 16'h7E01, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random(1'b0);
      run_frame("random", 16'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
